// File: rtl/periph_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module      : periph_mailbox_slave
// Description : Peripheral-crossbar responder exposing a word FIFO mailbox
//               through memory-mapped registers, with a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_mailbox_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int ID_WIDTH   = 9,
   parameter int DEPTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] add_i,
   input  logic                  wen_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   input  logic [ID_WIDTH-1:0]   id_i,
   output logic                  gnt_o,
   output logic                  r_valid_o,
   output logic                  r_opc_o,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_rdata_o,
   output logic                  irq_o
);

   localparam int                    c_PTR_W = $clog2(DEPTH);
   localparam int                    c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0]    c_DEPTH = c_CNT_W'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] c_BAD   = DATA_WIDTH'(32'hBADACCE5);

   localparam logic [2:0] c_TXPUSH = 3'd0;
   localparam logic [2:0] c_RXPOP  = 3'd1;
   localparam logic [2:0] c_STATUS = 3'd2;
   localparam logic [2:0] c_IRQ_EN = 3'd3;
   localparam logic [2:0] c_THRESH = 3'd4;
   localparam logic [2:0] c_CLEAR  = 3'd5;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_PTR_W-1:0]    r_wptr, r_rptr;
   logic [c_CNT_W-1:0]    r_count;
   logic                  r_ovf, r_unf;
   logic [1:0]            r_irq_en;
   logic [15:0]           r_thresh;
   logic                  r_valid, r_opc, r_irq;
   logic [ID_WIDTH-1:0]   r_id;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [2:0]            w_sel;
   logic                  w_write, w_full, w_empty;
   logic [DATA_WIDTH-1:0] w_push_data, w_status, w_rdata;
   logic                  w_push, w_pop, w_clear, w_set_ovf, w_set_unf, w_opc;
   logic [1:0]            w_irq_en_nxt;
   logic [15:0]           w_thresh_nxt;
   logic [c_CNT_W-1:0]    w_count_nxt;
   logic                  w_irq_nxt;

   // Only the word offset within the mailbox window selects a register.
   logic w_unused_addr;
   assign w_unused_addr = ^{add_i[ADDR_WIDTH-1:5], add_i[1:0]};

   assign gnt_o   = req_i;
   assign w_sel   = add_i[4:2];
   assign w_write = ~wen_i;
   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == '0);

   // Disabled byte lanes of a push are stored as zero.
   for (genvar b = 0; b < BE_WIDTH; b++) begin : g_be_mask
      assign w_push_data[8*b +: 8] = be_i[b] ? wdata_i[8*b +: 8] : 8'h00;
   end

   // Status word reflects the state before the current access.
   always_comb begin
      w_status        = '0;
      w_status[15:0]  = 16'(r_count);
      w_status[16]    = w_empty;
      w_status[17]    = w_full;
      w_status[18]    = r_ovf;
      w_status[19]    = r_unf;
   end

   // Decode the granted access into FIFO actions and the response payload.
   always_comb begin
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_clear      = 1'b0;
      w_set_ovf    = 1'b0;
      w_set_unf    = 1'b0;
      w_irq_en_nxt = r_irq_en;
      w_thresh_nxt = r_thresh;
      w_opc        = 1'b0;
      w_rdata      = '0;
      if (req_i) begin
         case (w_sel)
            c_TXPUSH: begin
               if (!w_write) begin
                  w_opc   = 1'b1;
                  w_rdata = c_BAD;
               end else if (w_full) begin
                  w_set_ovf = 1'b1;
                  w_opc     = 1'b1;
               end else begin
                  w_push = 1'b1;
               end
            end
            c_RXPOP: begin
               if (w_write) begin
                  w_opc   = 1'b1;
                  w_rdata = c_BAD;
               end else if (w_empty) begin
                  w_set_unf = 1'b1;
                  w_opc     = 1'b1;
               end else begin
                  w_pop   = 1'b1;
                  w_rdata = r_mem[r_rptr];
               end
            end
            c_STATUS: begin
               if (w_write) begin
                  w_opc   = 1'b1;
                  w_rdata = c_BAD;
               end else begin
                  w_rdata = w_status;
               end
            end
            c_IRQ_EN: begin
               if (w_write) begin
                  if (be_i[0]) w_irq_en_nxt = wdata_i[1:0];
               end else begin
                  w_rdata = DATA_WIDTH'(r_irq_en);
               end
            end
            c_THRESH: begin
               if (w_write) begin
                  if (be_i[0]) w_thresh_nxt[7:0]  = wdata_i[7:0];
                  if (be_i[1]) w_thresh_nxt[15:8] = wdata_i[15:8];
               end else begin
                  w_rdata = DATA_WIDTH'(r_thresh);
               end
            end
            c_CLEAR: begin
               if (w_write) begin
                  w_clear = 1'b1;
               end else begin
                  w_opc   = 1'b1;
                  w_rdata = c_BAD;
               end
            end
            default: begin
               w_opc   = 1'b1;
               w_rdata = c_BAD;
            end
         endcase
      end
   end

   assign w_count_nxt = w_clear ? '0 :
                        w_push  ? r_count + 1'b1 :
                        w_pop   ? r_count - 1'b1 : r_count;

   // Interrupt is evaluated on the post-access state so it lines up with the response.
   assign w_irq_nxt = (w_irq_en_nxt[0] & (w_count_nxt != '0)) |
                      (w_irq_en_nxt[1] & (w_thresh_nxt != 16'h0) &
                       (16'(w_count_nxt) >= w_thresh_nxt));

   // FIFO storage is not reset; only entries below the count are ever read.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= w_push_data;
   end

   // Mailbox state, control registers and registered response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_irq_en <= 2'b00;
         r_thresh <= 16'h0;
         r_valid  <= 1'b0;
         r_opc    <= 1'b0;
         r_id     <= '0;
         r_rdata  <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (w_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_ovf <= r_ovf | w_set_ovf;
            r_unf <= r_unf | w_set_unf;
         end
         r_count  <= w_count_nxt;
         r_irq_en <= w_irq_en_nxt;
         r_thresh <= w_thresh_nxt;
         r_valid  <= req_i;
         r_irq    <= w_irq_nxt;
         if (req_i) begin
            r_opc   <= w_opc;
            r_id    <= id_i;
            r_rdata <= w_rdata;
         end
      end
   end

   // A reset arriving in the response cycle suppresses that response.
   assign r_valid_o = r_valid & ~rst_i;
   assign r_opc_o   = r_opc & ~rst_i;
   assign r_id_o    = rst_i ? '0 : r_id;
   assign r_rdata_o = rst_i ? '0 : r_rdata;
   assign irq_o     = r_irq & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_periph_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_mailbox_slave
// Description : Self-checking bench for the mailbox responder; directed
//               scenarios plus randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_mailbox_slave;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = 4;
   localparam int IW    = 9;
   localparam int DEPTH = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_i;
   logic [AW-1:0] add_i;
   logic          wen_i;
   logic [DW-1:0] wdata_i;
   logic [BW-1:0] be_i;
   logic [IW-1:0] id_i;
   logic          gnt_o, r_valid_o, r_opc_o, irq_o;
   logic [IW-1:0] r_id_o;
   logic [DW-1:0] r_rdata_o;

   periph_mailbox_slave #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .DEPTH(DEPTH)
   ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .id_i(id_i), .gnt_o(gnt_o),
      .r_valid_o(r_valid_o), .r_opc_o(r_opc_o), .r_id_o(r_id_o),
      .r_rdata_o(r_rdata_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mailbox contents as a plain queue plus control state.
   logic [31:0] m_q[$];
   bit          m_ovf, m_unf;
   bit [1:0]    m_irq_en;
   bit [15:0]   m_thresh;
   logic [IW-1:0] m_last_id;
   logic [31:0]   m_last_rdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_irq();
      return (m_irq_en[0] && m_q.size() != 0) ||
             (m_irq_en[1] && m_thresh != 0 && m_q.size() >= int'(m_thresh));
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ovf = 0; m_unf = 0; m_irq_en = 0; m_thresh = 0;
      m_last_id = '0; m_last_rdata = '0;
   endtask

   // One bus cycle: drive, apply model, then check the response one cycle later.
   task automatic bus_cycle(input bit req, input logic [AW-1:0] addr, input bit wen,
                            input logic [31:0] wd, input logic [3:0] be, input logic [IW-1:0] id);
      bit          exp_opc;
      logic [31:0] rd;
      logic [31:0] st;
      int          sz;
      exp_opc = 0;
      rd      = 32'h0;
      @(negedge clk_i);
      req_i = req; add_i = addr; wen_i = wen; wdata_i = wd; be_i = be; id_i = id;
      #1 check_val("gnt", 32'(gnt_o), 32'(req));
      if (req) begin
         sz = m_q.size();
         case (addr[4:2])
            3'd0: if (wen) begin exp_opc = 1; rd = 32'hBADACCE5; end
                  else if (sz == DEPTH) begin m_ovf = 1; exp_opc = 1; end
                  else m_q.push_back(wd & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});
            3'd1: if (!wen) begin exp_opc = 1; rd = 32'hBADACCE5; end
                  else if (sz == 0) begin m_unf = 1; exp_opc = 1; end
                  else rd = m_q.pop_front();
            3'd2: if (!wen) begin exp_opc = 1; rd = 32'hBADACCE5; end
                  else begin
                     st = 32'(sz);
                     st[16] = (sz == 0); st[17] = (sz == DEPTH);
                     st[18] = m_ovf;     st[19] = m_unf;
                     rd = st;
                  end
            3'd3: if (!wen) begin if (be[0]) m_irq_en = wd[1:0]; end
                  else rd = 32'(m_irq_en);
            3'd4: if (!wen) begin
                     if (be[0]) m_thresh[7:0]  = wd[7:0];
                     if (be[1]) m_thresh[15:8] = wd[15:8];
                  end else rd = 32'(m_thresh);
            3'd5: if (!wen) begin m_q.delete(); m_ovf = 0; m_unf = 0; end
                  else begin exp_opc = 1; rd = 32'hBADACCE5; end
            default: begin exp_opc = 1; rd = 32'hBADACCE5; end
         endcase
         m_last_id    = id;
         m_last_rdata = rd;
      end
      @(posedge clk_i);
      #1;
      check_val("r_valid", 32'(r_valid_o), 32'(req));
      if (r_valid_o) check_val("r_opc", 32'(r_opc_o), 32'(exp_opc));
      check_val("r_id", 32'(r_id_o), 32'(m_last_id));
      check_val("r_rdata", r_rdata_o, m_last_rdata);
      check_val("irq", 32'(irq_o), 32'(model_irq()));
   endtask

   task automatic idle();
      bus_cycle(0, '0, 1, '0, '0, '0);
   endtask
   task automatic push(input logic [31:0] d, input logic [3:0] be, input logic [IW-1:0] id);
      bus_cycle(1, 32'h00, 0, d, be, id);
   endtask
   task automatic pop(input logic [IW-1:0] id);
      bus_cycle(1, 32'h04, 1, '0, 4'hF, id);
   endtask
   task automatic rd_reg(input logic [2:0] sel, input logic [IW-1:0] id);
      bus_cycle(1, {27'h0, sel, 2'b00}, 1, '0, 4'hF, id);
   endtask
   task automatic wr_reg(input logic [2:0] sel, input logic [31:0] d, input logic [3:0] be,
                         input logic [IW-1:0] id);
      bus_cycle(1, {27'h0, sel, 2'b00}, 0, d, be, id);
   endtask

   initial begin
      logic [31:0] status_before;
      rst_i = 1; req_i = 0; add_i = '0; wen_i = 1; wdata_i = '0; be_i = '0; id_i = '0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1 check_val("rst_valid", 32'(r_valid_o), 32'h0);
      @(negedge clk_i) rst_i = 0;

      // Reset state and first STATUS read
      idle();
      check_val("rst_opc", 32'(r_opc_o), 32'h0);
      rd_reg(3'd2, 9'h004);
      check_val("status_reset", r_rdata_o, 32'h00010000);
      check_val("status_id", 32'(r_id_o), 32'h004);

      // Back-to-back pushes, in-order pops, underflow
      push(32'h11111111, 4'hF, 9'h001);
      push(32'h22222222, 4'hF, 9'h001);
      push(32'h33333333, 4'hF, 9'h001);
      pop(9'h100); pop(9'h100); pop(9'h100);
      pop(9'h100);
      check_val("underflow_opc", 32'(r_opc_o), 32'h1);
      rd_reg(3'd2, 9'h002);
      check_val("underflow_sticky", 32'(r_rdata_o[19]), 32'h1);

      // Byte-masked push
      push(32'hAABBCCDD, 4'b0101, 9'h008);
      pop(9'h008);
      check_val("be_mask", r_rdata_o, 32'h00BB00DD);

      // Fill, overflow, wrap, clear
      wr_reg(3'd5, 32'h0, 4'hF, 9'h010);
      for (int i = 0; i < DEPTH; i++) push(32'hC0DE0000 + 32'(i), 4'hF, 9'h010);
      push(32'hDEADDEAD, 4'hF, 9'h010);
      check_val("overflow_opc", 32'(r_opc_o), 32'h1);
      rd_reg(3'd2, 9'h010);
      check_val("status_full", r_rdata_o, 32'h00060008);
      for (int i = 0; i < 5; i++) begin
         pop(9'h020);
         push(32'h0E0E0000 + 32'(i), 4'hF, 9'h020);
      end
      wr_reg(3'd5, 32'h0, 4'hF, 9'h010);
      rd_reg(3'd2, 9'h010);
      check_val("status_clear", r_rdata_o, 32'h00010000);

      // Threshold and not-empty interrupts
      wr_reg(3'd3, 32'h2, 4'h1, 9'h040);
      wr_reg(3'd4, 32'h3, 4'h3, 9'h040);
      push(32'h1, 4'hF, 9'h040);
      push(32'h2, 4'hF, 9'h040);
      check_val("irq_below_thr", 32'(irq_o), 32'h0);
      push(32'h3, 4'hF, 9'h040);
      check_val("irq_at_thr", 32'(irq_o), 32'h1);
      pop(9'h040);
      check_val("irq_after_pop", 32'(irq_o), 32'h0);
      wr_reg(3'd3, 32'h1, 4'h1, 9'h040);
      check_val("irq_not_empty", 32'(irq_o), 32'h1);

      // Illegal accesses leave state untouched
      rd_reg(3'd2, 9'h001);
      status_before = r_rdata_o;
      bus_cycle(1, 32'h18, 0, 32'h12345678, 4'hF, 9'h001);
      check_val("bad_addr", r_rdata_o, 32'hBADACCE5);
      rd_reg(3'd0, 9'h001);
      check_val("bad_read_opc", 32'(r_opc_o), 32'h1);
      rd_reg(3'd2, 9'h001);
      check_val("status_unchanged", r_rdata_o, status_before);

      // Reset in the response cycle of a granted push
      @(negedge clk_i);
      req_i = 1; add_i = 32'h0; wen_i = 0; wdata_i = 32'h5A5A5A5A; be_i = 4'hF; id_i = 9'h001;
      @(posedge clk_i);
      #1 rst_i = 1; req_i = 0;
      #1 check_val("rst_pulse_valid", 32'(r_valid_o), 32'h0);
      @(posedge clk_i);
      #1 rst_i = 0;
      model_reset();
      idle();
      rd_reg(3'd2, 9'h004);
      check_val("rst_pulse_count", 32'(r_rdata_o[15:0]), 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int unsigned r, sel;
         bit          wen;
         logic [AW-1:0] a;
         r = $urandom_range(0, 15);
         sel = (r < 5) ? 0 : (r < 9) ? 1 : (r < 11) ? 2 : (r < 12) ? 3 :
               (r < 13) ? 4 : (r < 14) ? 5 : (r < 15) ? 6 : 7;
         case (sel)
            0, 5:    wen = 0;
            1, 2:    wen = 1;
            default: wen = $urandom_range(0, 1) == 1;
         endcase
         if ($urandom_range(0, 7) == 0) wen = ~wen;
         a = ($urandom & ~32'h1C) | (32'(sel) << 2);
         if ($urandom_range(0, 4) == 0) idle();
         else bus_cycle(1, a, wen, $urandom, 4'($urandom_range(0, 15)),
                        9'(1) << $urandom_range(0, 8));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
